fwd_hazard_ctrl: RTL

- Control-side counterpart of the 32-bit 3:1 operand-select muxes in the pipelined MIPS datapath.
- Tracks the destination registers of in-flight instructions in shadow EX/MEM/WB stage registers.
- Generates the 2-bit forwarding selects for both ALU operand muxes.
- Detects load-use hazards and asserts a one-cycle stall that inserts a bubble. Also keeps a saturating stall counter for performance debug.

---
 rtl/fwd_hazard_ctrl_if.sv | 37 +++
 rtl/fwd_hazard_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage instruction fields into the forwarding/hazard controller, and the
// operand-select and stall controls back out to the datapath.
//
// ID valid/stall contract: an ID instruction is offered whenever id_valid = 1.
// It is accepted into EX on a rising edge where stall = 0 and flush = 0. While
// stall = 1 the source must hold the same ID fields for the next cycle. A
// flushed instruction is dropped and never re-offered.
interface fwd_hazard_ctrl_if #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
);
   logic            id_valid;
   logic [RA_W-1:0] id_rs;
   logic [RA_W-1:0] id_rt;
   logic            id_uses_rs;
   logic            id_uses_rt;
   logic [RA_W-1:0] id_dst;
   logic            id_reg_wr;
   logic            id_is_load;
   logic            flush;
   logic [1:0]      fwd_a_sel;
   logic [1:0]      fwd_b_sel;
   logic            stall;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_dst, id_reg_wr, id_is_load, flush,
      input  fwd_a_sel, fwd_b_sel, stall, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_dst, id_reg_wr, id_is_load, flush,
      output fwd_a_sel, fwd_b_sel, stall, stall_count
   );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for the 5-stage MIPS pipeline.
// Shadow copies of the EX/MEM/WB destination info drive the operand mux
// selects (0 = regfile, 1 = WB data, 2 = EX/MEM ALU result) and a one-cycle
// stall whenever the ID instruction consumes the result of a load in EX.
module fwd_hazard_ctrl #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   fwd_hazard_ctrl_if.slave bus
);

   // EX shadow stage
   logic            ex_valid;
   logic [RA_W-1:0] ex_rs;
   logic [RA_W-1:0] ex_rt;
   logic            ex_uses_rs;
   logic            ex_uses_rt;
   logic [RA_W-1:0] ex_dst;
   logic            ex_reg_wr;
   logic            ex_is_load;
   // MEM shadow stage
   logic            mem_valid;
   logic [RA_W-1:0] mem_dst;
   logic            mem_reg_wr;
   logic            mem_is_load;
   // WB shadow stage (the load flag is not needed once the data is written back)
   logic            wb_valid;
   logic [RA_W-1:0] wb_dst;
   logic            wb_reg_wr;

   logic [CNT_W-1:0] stall_cnt;
   logic             stall_w;
   logic             mem_wr_ok;
   logic             wb_wr_ok;
   logic [1:0]       sel_a;
   logic [1:0]       sel_b;

   // A stage can supply a forward only if it really writes a non-zero register.
   assign mem_wr_ok = mem_valid & mem_reg_wr & (mem_dst != '0);
   assign wb_wr_ok  = wb_valid & wb_reg_wr & (wb_dst != '0);

   // Load-use detection against the instruction currently in EX; flush overrides it.
   assign stall_w = bus.id_valid & ~bus.flush & ex_valid & ex_is_load & ex_reg_wr &
                    (ex_dst != '0) &
                    ((bus.id_uses_rs & (bus.id_rs == ex_dst)) |
                     (bus.id_uses_rt & (bus.id_rt == ex_dst)));

   // Operand selects for the EX instruction; the younger MEM result beats WB.
   always_comb begin
      sel_a = 2'd0;
      sel_b = 2'd0;
      if (ex_valid && ex_uses_rs) begin
         if (mem_wr_ok && (mem_dst == ex_rs))     sel_a = 2'd2;
         else if (wb_wr_ok && (wb_dst == ex_rs))  sel_a = 2'd1;
      end
      if (ex_valid && ex_uses_rt) begin
         if (mem_wr_ok && (mem_dst == ex_rt))     sel_b = 2'd2;
         else if (wb_wr_ok && (wb_dst == ex_rt))  sel_b = 2'd1;
      end
   end

   assign bus.fwd_a_sel   = sel_a;
   assign bus.fwd_b_sel   = sel_b;
   assign bus.stall       = stall_w;
   assign bus.stall_count = stall_cnt;

   // Advance the shadow pipeline; a stalled or flushed ID slot enters EX as a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_uses_rs  <= 1'b0;
         ex_uses_rt  <= 1'b0;
         ex_dst      <= '0;
         ex_reg_wr   <= 1'b0;
         ex_is_load  <= 1'b0;
         mem_valid   <= 1'b0;
         mem_dst     <= '0;
         mem_reg_wr  <= 1'b0;
         mem_is_load <= 1'b0;
         wb_valid    <= 1'b0;
         wb_dst      <= '0;
         wb_reg_wr   <= 1'b0;
      end else begin
         wb_valid    <= mem_valid;
         wb_dst      <= mem_dst;
         wb_reg_wr   <= mem_reg_wr;
         mem_valid   <= ex_valid;
         mem_dst     <= ex_dst;
         mem_reg_wr  <= ex_reg_wr;
         mem_is_load <= ex_is_load;
         if (!stall_w && !bus.flush) begin
            ex_valid   <= bus.id_valid;
            ex_rs      <= bus.id_rs;
            ex_rt      <= bus.id_rt;
            ex_uses_rs <= bus.id_uses_rs;
            ex_uses_rt <= bus.id_uses_rt;
            ex_dst     <= bus.id_dst;
            ex_reg_wr  <= bus.id_reg_wr;
            ex_is_load <= bus.id_is_load;
         end else begin
            ex_valid   <= 1'b0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_uses_rs <= 1'b0;
            ex_uses_rt <= 1'b0;
            ex_dst     <= '0;
            ex_reg_wr  <= 1'b0;
            ex_is_load <= 1'b0;
         end
      end
   end

   // Saturating count of stall cycles for performance debug.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall_w && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Load data is only available at WB; the stall must make a MEM-stage forward
   // of a load impossible.
   a_no_mem_load_fwd : assert property (@(posedge clk) disable iff (!rst_n)
      !(mem_is_load && ((sel_a == 2'd2) || (sel_b == 2'd2))));

endmodule
